// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: frame state encodings and default link constants.
// Used by both the receiver and the transmitter.
package uart_rx_pkg;

  localparam int DEF_DATA_LEN     = 8;
  localparam int DEF_CLKS_PER_BIT = 2604;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START_BIT = 3'd1,
    ST_DATA_BITS = 3'd2,
    ST_STOP_BIT  = 3'd3,
    ST_FINISH    = 3'd4
  } uart_state_e;

  // Counter width for a modulus of n; never zero bits wide.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side serial line and received-byte bundle.
// The master modport is the receiver; the slave modport is the consumer/line driver.
interface uart_rx_if
  import uart_rx_pkg::*;
#(
  parameter int DATA_LEN = DEF_DATA_LEN
);

  logic                rx_serial;
  logic [DATA_LEN-1:0] rx_data;
  logic                rx_valid;
  logic                rx_busy;
  logic                frame_err;

  modport master (
    input  rx_serial,
    output rx_data,
    output rx_valid,
    output rx_busy,
    output frame_err
  );

  modport slave (
    output rx_serial,
    input  rx_data,
    input  rx_valid,
    input  rx_busy,
    input  frame_err
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// The reset value is a parameter so idle-high and idle-low lines can share it.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style framing, mid-bit sampling from the start-bit centre.
// Emits one-cycle rx_valid / frame_err pulses; rx_data holds the last good byte.
//
//   state        | meaning
//   ST_IDLE      | waiting for a falling edge on the synchronized line
//   ST_START_BIT | counting to the start-bit centre, rejecting glitches
//   ST_DATA_BITS | sampling DATA_LEN bits, LSB first, one per bit period
//   ST_STOP_BIT  | sampling the stop bit; good -> rx_valid, low -> frame_err
//   ST_FINISH    | one-cycle gap before IDLE
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_LEN     = DEF_DATA_LEN,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  uart_rx_if.master  bus
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int BW = cnt_width(DATA_LEN);

  localparam logic [CW-1:0] HALF     = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_LEN - 1);

  logic rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.rx_serial),
    .q     (rx_s)
  );

  uart_state_e         state_q,     state_d;
  logic [CW-1:0]       clk_count_q, clk_count_d;
  logic [BW-1:0]       bit_count_q, bit_count_d;
  logic [DATA_LEN-1:0] shift_q,     shift_d;
  logic [DATA_LEN-1:0] rx_data_q,   rx_data_d;
  logic                rx_valid_q,  rx_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                rx_d_q;
  logic [1:0]          warm_q,      warm_d;

  // The synchronizer and rx_d come out of reset high; edges are ignored until
  // they hold real line samples, so a line already low at release starts nothing.
  assign warm_d = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      clk_count_q <= '0;
      bit_count_q <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_d_q      <= 1'b1;
      warm_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      clk_count_q <= clk_count_d;
      bit_count_q <= bit_count_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      rx_d_q      <= rx_s;
      warm_q      <= warm_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clk_count_d = clk_count_q;
    bit_count_d = bit_count_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clk_count_d = '0;
        bit_count_d = '0;
        if (warm_q == 2'd3 && rx_d_q && !rx_s) begin
          state_d = ST_START_BIT;
        end
      end

      ST_START_BIT: begin
        if (clk_count_q == HALF) begin
          clk_count_d = '0;
          bit_count_d = '0;
          state_d     = rx_s ? ST_IDLE : ST_DATA_BITS;
        end else begin
          clk_count_d = clk_count_q + 1'b1;
        end
      end

      ST_DATA_BITS: begin
        if (clk_count_q == LAST_CLK) begin
          clk_count_d          = '0;
          shift_d[bit_count_q] = rx_s;
          if (bit_count_q == LAST_BIT) begin
            state_d = ST_STOP_BIT;
          end else begin
            bit_count_d = bit_count_q + 1'b1;
          end
        end else begin
          clk_count_d = clk_count_q + 1'b1;
        end
      end

      ST_STOP_BIT: begin
        if (clk_count_q == LAST_CLK) begin
          clk_count_d = '0;
          state_d     = ST_FINISH;
          if (rx_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          clk_count_d = clk_count_q + 1'b1;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d     = ST_IDLE;
        clk_count_d = '0;
        bit_count_d = '0;
      end
    endcase
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.rx_busy   = (state_q == ST_START_BIT) ||
                         (state_q == ST_DATA_BITS) ||
                         (state_q == ST_STOP_BIT);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit, 8 data bits.
// Good frames push their byte to a scoreboard queue; a negedge monitor pops and checks.
module tb_uart_rx;

  localparam int CPB     = 16;
  localparam int DL      = 8;
  localparam int CLK_P   = 10;
  localparam int BIT_T   = CPB * CLK_P;
  localparam int LAT_NOM = 2 + 1 + (CPB - 1) / 2 + DL * CPB + CPB;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  uart_rx_if #(.DATA_LEN(DL)) bus ();

  uart_rx #(.DATA_LEN(DL), .CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #(CLK_P / 2) clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frame_start_cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int busy_cycles = 0;
  int lat;
  logic prev_valid = 1'b0;
  logic prev_err = 1'b0;
  logic [DL-1:0] exp_q[$];
  logic [DL-1:0] exp_b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rx_busy) busy_cycles++;
      if (bus.rx_valid) begin
        valid_cnt++;
        chk("valid_err_overlap", {31'd0, bus.frame_err}, 32'd0);
        chk("valid_width", {31'd0, prev_valid}, 32'd0);
        lat = cyc - frame_start_cyc;
        chk("valid_latency", {31'd0, (lat >= LAT_NOM - 1 && lat <= LAT_NOM + 1)}, 32'd1);
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_valid: observed data %0h expected no pulse", bus.rx_data);
        end
        if (exp_q.size() > 0) begin
          exp_b = exp_q.pop_front();
          chk("rx_data", {24'd0, bus.rx_data}, {24'd0, exp_b});
        end
      end
      if (bus.frame_err) begin
        err_cnt++;
        chk("err_width", {31'd0, prev_err}, 32'd0);
      end
    end
    prev_valid = bus.rx_valid;
    prev_err   = bus.frame_err;
  end

  task automatic send_byte(input logic [DL-1:0] b, input logic stop_bit, input int bit_t);
    bus.rx_serial   = 1'b0;
    frame_start_cyc = cyc;
    #(bit_t);
    for (int i = 0; i < DL; i++) begin
      bus.rx_serial = b[i];
      #(bit_t);
    end
    bus.rx_serial = stop_bit;
    #(bit_t);
  endtask

  task automatic align();
    @(negedge clk);
    #2;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.rx_busy) break;
    end
    repeat (3) @(negedge clk);
    chk(tag, exp_q.size(), 32'd0);
    chk("busy_idle", {31'd0, bus.rx_busy}, 32'd0);
  endtask

  initial begin
    bus.rx_serial = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", {24'd0, bus.rx_data}, 32'd0);
    chk("rst_valid", {31'd0, bus.rx_valid}, 32'd0);
    chk("rst_err", {31'd0, bus.frame_err}, 32'd0);
    chk("rst_busy", {31'd0, bus.rx_busy}, 32'd0);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    // Single good frame
    align();
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, BIT_T);
    drain("drain_a5");
    chk("a5_data", {24'd0, bus.rx_data}, 32'hA5);
    chk("a5_valid_cnt", valid_cnt, 32'd1);
    chk("a5_err_cnt", err_cnt, 32'd0);

    // Back-to-back frames, no idle gap
    align();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h3C);
    send_byte(8'h00, 1'b1, BIT_T);
    send_byte(8'hFF, 1'b1, BIT_T);
    send_byte(8'h3C, 1'b1, BIT_T);
    drain("drain_b2b");
    chk("b2b_valid_cnt", valid_cnt, 32'd4);
    chk("b2b_data", {24'd0, bus.rx_data}, 32'h3C);

    // Framing error followed by a held-low break
    align();
    send_byte(8'h55, 1'b0, BIT_T);
    repeat (100) @(negedge clk);
    chk("brk_err_cnt", err_cnt, 32'd1);
    chk("brk_valid_cnt", valid_cnt, 32'd4);
    chk("brk_data_kept", {24'd0, bus.rx_data}, 32'h3C);
    chk("brk_busy", {31'd0, bus.rx_busy}, 32'd0);
    bus.rx_serial = 1'b1;
    repeat (20) @(negedge clk);
    chk("brk_rise_no_frame", valid_cnt + err_cnt, 32'd5);
    align();
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1, BIT_T);
    drain("drain_81");
    chk("post_brk_data", {24'd0, bus.rx_data}, 32'h81);
    chk("post_brk_valid_cnt", valid_cnt, 32'd5);

    // Five-cycle low glitch on the idle line
    busy_cycles = 0;
    align();
    bus.rx_serial = 1'b0;
    #(5 * CLK_P);
    bus.rx_serial = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_busy_bound", {31'd0, (busy_cycles > 0 && busy_cycles <= (CPB - 1) / 2 + 1)}, 32'd1);
    chk("glitch_no_pulse", valid_cnt + err_cnt, 32'd6);
    chk("glitch_data_kept", {24'd0, bus.rx_data}, 32'h81);

    // Reset during bit 4 of 0xC3, held for 3 cycles
    align();
    fork
      send_byte(8'hC3, 1'b1, BIT_T);
      begin
        #(5 * BIT_T + 3 * CLK_P);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_rst_data", {24'd0, bus.rx_data}, 32'd0);
        chk("mid_rst_busy", {31'd0, bus.rx_busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, bus.rx_valid}, 32'd0);
        reset = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    chk("post_rst_no_pulse", valid_cnt + err_cnt, 32'd6);
    chk("post_rst_data", {24'd0, bus.rx_data}, 32'd0);
    chk("post_rst_busy", {31'd0, bus.rx_busy}, 32'd0);
    align();
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b1, BIT_T);
    drain("drain_12");
    chk("rst_recover_data", {24'd0, bus.rx_data}, 32'h12);

    // Baud skew: bit periods of 15.5 and 16.5 clocks
    align();
    exp_q.push_back(8'h6B);
    send_byte(8'h6B, 1'b1, BIT_T - CLK_P / 2);
    drain("drain_fast");
    chk("fast_data", {24'd0, bus.rx_data}, 32'h6B);
    bus.rx_serial = 1'b1;
    repeat (10) @(negedge clk);
    align();
    exp_q.push_back(8'h6B);
    send_byte(8'h6B, 1'b1, BIT_T + CLK_P / 2);
    drain("drain_slow");
    chk("slow_data", {24'd0, bus.rx_data}, 32'h6B);

    chk("final_valid_cnt", valid_cnt, 32'd8);
    chk("final_err_cnt", err_cnt, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
